// File: rtl/ycbcr422_frame_sequencer.sv
// Frame-timing sequencer feeding the YCbCr 4:2:2 -> 4:4:4 converter from a FWFT FIFO.
// Generates vsync/href/clken with programmable geometry, start/stop control and a trailing clken drain.
module ycbcr422_frame_sequencer #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK     = 45,
  parameter int VSYNC_LEN   = 3,
  parameter int CLKEN_DIV   = 1,
  parameter int DRAIN_SLOTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop_req,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd,
  output logic        per_frame_vsync,
  output logic        per_frame_href,
  output logic        per_frame_clken,
  output logic [15:0] per_frame_YCbCr,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int DW = (DRAIN_SLOTS > 1) ? $clog2(DRAIN_SLOTS) : 1;
  localparam logic [11:0]   H_LAST     = 12'(H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0]   H_ACT      = 12'(H_ACTIVE);
  localparam logic [10:0]   V_LAST     = 11'(V_BLANK + V_ACTIVE - 1);
  localparam logic [10:0]   V_BL       = 11'(V_BLANK);
  localparam logic [10:0]   V_SYNC     = 11'(VSYNC_LEN);
  localparam logic [3:0]    DIV_LAST   = 4'(CLKEN_DIV - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_SLOTS > 0 ? DRAIN_SLOTS - 1 : 0);
  localparam logic [15:0]   BLACK      = 16'h8010;

  typedef enum logic [1:0] {IDLE, FRAME, DRAIN} state_t;

  state_t        state;
  logic [3:0]    div_cnt;
  logic [11:0]   h_cnt;
  logic [10:0]   v_cnt;
  logic [DW-1:0] drain_cnt;
  logic          stop_pend;

  logic tick, h_last, v_last, active, stop_now;

  always_comb begin
    tick     = (state != IDLE) && (div_cnt == DIV_LAST);
    h_last   = (h_cnt == H_LAST);
    v_last   = (v_cnt == V_LAST);
    active   = (state == FRAME) && (v_cnt >= V_BL) && (h_cnt < H_ACT);
    stop_now = stop_pend | stop_req;
  end

  // FWFT head is consumed in the same clk the slot samples it, so the pop stays combinational.
  assign fifo_rd = tick && active && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      div_cnt         <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      drain_cnt       <= '0;
      stop_pend       <= 1'b0;
      busy            <= 1'b0;
      underflow       <= 1'b0;
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_frame_YCbCr <= '0;
      frame_done      <= 1'b0;
    end else begin
      per_frame_clken <= 1'b0;
      frame_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FRAME;
            busy      <= 1'b1;
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            drain_cnt <= '0;
            underflow <= 1'b0;
            stop_pend <= stop_req;
          end
        end
        FRAME, DRAIN: begin
          if (stop_req) stop_pend <= 1'b1;
          div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
          if (tick) begin
            per_frame_clken <= 1'b1;
            if (state == FRAME) begin
              per_frame_vsync <= (v_cnt < V_SYNC);
              per_frame_href  <= active;
              per_frame_YCbCr <= active ? (fifo_empty ? BLACK : fifo_dout) : 16'h0000;
              if (active && fifo_empty) underflow <= 1'b1;
              if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
              end else begin
                h_cnt <= h_cnt + 12'd1;
              end
              if (h_last && v_last) begin
                frame_done <= 1'b1;
                if (!continuous || stop_now) begin
                  drain_cnt <= '0;
                  if (DRAIN_SLOTS == 0) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                  end else begin
                    state <= DRAIN;
                  end
                end
              end
            end else begin
              // Drain slots only keep the converter pipeline clocking out its last pixels.
              per_frame_vsync <= 1'b0;
              per_frame_href  <= 1'b0;
              per_frame_YCbCr <= 16'h0000;
              drain_cnt       <= drain_cnt + 1'b1;
              if (drain_cnt == DRAIN_LAST) begin
                state     <= IDLE;
                busy      <= 1'b0;
                stop_pend <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr422_frame_sequencer.sv
// Directed bench: small 6x5 frame geometry, divider 1 on instance a and divider 3 on instance b.
module tb_ycbcr422_frame_sequencer;

  localparam int HA = 4, HB = 2, VA = 2, VB = 3, VS = 1, DR = 4;
  localparam int HT = HA + HB;
  localparam int FS = HT * (VA + VB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_a = 0, cont_a = 0, stop_a = 0;
  logic        empty_a, rd_a, vs_a, hr_a, ce_a, busy_a, fd_a, uf_a;
  logic [15:0] dout_a, yc_a;
  logic        start_b = 0, cont_b = 0, stop_b = 0;
  logic        empty_b, rd_b, vs_b, hr_b, ce_b, busy_b, fd_b, uf_b;
  logic [15:0] dout_b, yc_b;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  assign empty_a = (rp_a == wp_a);
  assign dout_a  = mem_a[rp_a];
  assign empty_b = (rp_b == wp_b);
  assign dout_b  = mem_b[rp_b];
  always @(posedge clk) if (rd_a && !empty_a) rp_a <= rp_a + 1;
  always @(posedge clk) if (rd_b && !empty_b) rp_b <= rp_b + 1;

  ycbcr422_frame_sequencer #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
    .VSYNC_LEN(VS), .CLKEN_DIV(1), .DRAIN_SLOTS(DR)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .stop_req(stop_a),
    .fifo_empty(empty_a), .fifo_dout(dout_a), .fifo_rd(rd_a),
    .per_frame_vsync(vs_a), .per_frame_href(hr_a), .per_frame_clken(ce_a),
    .per_frame_YCbCr(yc_a), .busy(busy_a), .frame_done(fd_a), .underflow(uf_a));

  ycbcr422_frame_sequencer #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
    .VSYNC_LEN(VS), .CLKEN_DIV(3), .DRAIN_SLOTS(DR)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .stop_req(stop_b),
    .fifo_empty(empty_b), .fifo_dout(dout_b), .fifo_rd(rd_b),
    .per_frame_vsync(vs_b), .per_frame_href(hr_b), .per_frame_clken(ce_b),
    .per_frame_YCbCr(yc_b), .busy(busy_b), .frame_done(fd_b), .underflow(uf_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {vsync, href, frame_done} for slot s of a run of the given number of frames.
  function automatic logic [2:0] flags(input int s, input int frames);
    int r, h, v;
    if (s >= frames * FS) return 3'b000;
    r = s % FS;
    h = r % HT;
    v = r / HT;
    return {v < VS, (v >= VB) && (h < HA), r == FS - 1};
  endfunction

  task automatic load_a(input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[wp_a] = {8'(8'h40 + wp_a), 8'(wp_a)};
      wp_a++;
    end
  endtask

  task automatic load_b(input int n);
    for (int i = 0; i < n; i++) begin
      mem_b[wp_b] = {8'(8'hA0 + wp_b), 8'(8'h30 + wp_b)};
      wp_b++;
    end
  endtask

  task automatic pulse_start_a(input logic with_stop);
    @(negedge clk);
    start_a = 1'b1;
    stop_a  = with_stop;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
  endtask

  // Follows instance a from the clk after start until idle, checking every clken slot.
  task automatic watch_a(input string tag, input int frames, input int stop_at, input int start_at);
    int s, cyc, ptr, ptr0, pops, total;
    logic uf_exp;
    logic [2:0] fl;
    logic [15:0] ey;
    s = 0; cyc = 0; pops = 0; uf_exp = 1'b0;
    ptr = rp_a; ptr0 = rp_a;
    total = frames * FS + DR;
    chk($sformatf("%s_busy_after_start", tag), busy_a, 1);
    chk($sformatf("%s_uf_cleared", tag), uf_a, 0);
    while (s < total && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      stop_a  = (cyc == stop_at);
      start_a = (cyc == start_at);
      if (rd_a) begin
        pops++;
        chk($sformatf("%s_pop_when_empty", tag), empty_a, 0);
      end
      if (ce_a) begin
        fl = flags(s, frames);
        if (fl[1]) begin
          if (ptr < wp_a) begin ey = mem_a[ptr]; ptr++; end
          else begin ey = 16'h8010; uf_exp = 1'b1; end
        end else ey = 16'h0000;
        chk($sformatf("%s_vsync_s%0d", tag, s), vs_a, fl[2]);
        chk($sformatf("%s_href_s%0d", tag, s), hr_a, fl[1]);
        chk($sformatf("%s_ycbcr_s%0d", tag, s), yc_a, ey);
        chk($sformatf("%s_fdone_s%0d", tag, s), fd_a, fl[0]);
        chk($sformatf("%s_uflow_s%0d", tag, s), uf_a, uf_exp);
        if (s < total - 1) chk($sformatf("%s_busy_s%0d", tag, s), busy_a, 1);
        s++;
      end
    end
    start_a = 1'b0;
    stop_a  = 1'b0;
    chk($sformatf("%s_slot_count", tag), s, total);
    chk($sformatf("%s_pop_count", tag), pops, ptr - ptr0);
    @(negedge clk);
    chk($sformatf("%s_idle_busy", tag), busy_a, 0);
    chk($sformatf("%s_idle_outs", tag), {ce_a, vs_a, hr_a, fd_a, yc_a}, 0);
    repeat (5) @(negedge clk);
    chk($sformatf("%s_no_extra_clken", tag), ce_a, 0);
  endtask

  initial begin
    int s, cyc, ptr;
    logic [2:0] fl;
    logic [15:0] ey, ly;
    logic lv, lh;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_outs", {rd_a, vs_a, hr_a, ce_a, yc_a, busy_a, fd_a, uf_a}, 0);
    chk("rst_b_outs", {rd_b, vs_b, hr_b, ce_b, yc_b, busy_b, fd_b, uf_b}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_a_busy", busy_a, 0);

    // 1: single frame, 8 words
    load_a(8);
    pulse_start_a(1'b0);
    watch_a("t1", 1, -1, -1);

    // 2: three continuous frames, stop requested inside frame 3
    cont_a = 1'b1;
    load_a(24);
    pulse_start_a(1'b0);
    watch_a("t2", 3, 70, -1);
    cont_a = 1'b0;

    // 3: underflow with 5 words
    load_a(5);
    pulse_start_a(1'b0);
    watch_a("t3", 1, -1, -1);
    chk("t3_fifo_drained", rp_a, wp_a);

    // 5: reset at slot 20 (only 2 words so underflow is set when reset hits)
    load_a(2);
    pulse_start_a(1'b0);
    chk("t5_uf_cleared_by_start", uf_a, 0);
    s = 0; cyc = 0;
    while (s < 21 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ce_a) s++;
    end
    chk("t5_reached_slot20", s, 21);
    chk("t5_uf_before_rst", uf_a, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {rd_a, vs_a, hr_a, ce_a, yc_a, busy_a, fd_a, uf_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_rst", {ce_a, busy_a}, 0);
    load_a(8);
    pulse_start_a(1'b0);
    watch_a("t5", 1, -1, -1);

    // 6: start+stop together with continuous=1 gives one frame; a mid-frame start is ignored
    cont_a = 1'b1;
    load_a(16);
    pulse_start_a(1'b1);
    watch_a("t6", 1, -1, 10);
    cont_a = 1'b0;

    // 4: divider 3 on instance b
    load_b(8);
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("t4_busy_after_start", busy_b, 1);
    s = 0; cyc = 0; ptr = rp_b;
    lv = 1'b0; lh = 1'b0; ly = 16'h0000;
    while (s < FS + DR && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rd_b) chk("t4_pop_when_empty", empty_b, 0);
      if (ce_b) begin
        fl = flags(s, 1);
        if (fl[1]) begin
          if (ptr < wp_b) begin ey = mem_b[ptr]; ptr++; end
          else ey = 16'h8010;
        end else ey = 16'h0000;
        chk($sformatf("t4_clken_time_s%0d", s), cyc, 3 + 3 * s);
        chk($sformatf("t4_vsync_s%0d", s), vs_b, fl[2]);
        chk($sformatf("t4_href_s%0d", s), hr_b, fl[1]);
        chk($sformatf("t4_ycbcr_s%0d", s), yc_b, ey);
        chk($sformatf("t4_fdone_s%0d", s), fd_b, fl[0]);
        lv = fl[2]; lh = fl[1]; ly = ey;
        s++;
      end else begin
        chk($sformatf("t4_hold_c%0d", cyc), {vs_b, hr_b, yc_b, fd_b}, {lv, lh, ly, 1'b0});
      end
    end
    chk("t4_slot_count", s, FS + DR);
    chk("t4_frame_clks", cyc, 3 + 3 * (FS + DR - 1));
    chk("t4_pops", ptr - 0, rp_b);
    chk("t4_underflow", uf_b, 0);
    @(negedge clk);
    chk("t4_idle", {busy_b, ce_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
